// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive path: FSM states, CRC-15 constants,
// frame field widths and error encodings.
package can_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOF,
    S_ID,
    S_RTR,
    S_IDE,
    S_R0,
    S_DLC,
    S_DATA,
    S_CRC,
    S_CRC_DEL,
    S_ACK,
    S_ACK_DEL,
    S_EOF,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_STUFF = 2'd1,
    ERR_CRC   = 2'd2,
    ERR_FORM  = 2'd3
  } err_code_e;

  localparam int             CRC_W    = 15;
  localparam logic [14:0]    CRC_POLY = 15'h4599;

  localparam int ID_W          = 11;
  localparam int DLC_W         = 4;
  localparam int EOF_W         = 7;
  localparam int ERR_RECESSIVE = 11;
  localparam int STUFF_RUN     = 5;

endpackage

// File: rtl/can_rx_if.sv
// Bus line, ACK drive and host-facing frame outputs of the CAN receiver.
interface can_rx_if;
  logic        rx;
  logic        tx;
  logic        ack_en;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  err_code;
  logic        busy;

  // The receiver side drives the frame outputs and the ACK line.
  modport master (
    input  rx, ack_en,
    output tx, rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, rx_err, err_code, busy
  );

  modport slave (
    output rx, ack_en,
    input  tx, rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, rx_err, err_code, busy
  );
endinterface

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 (x^15+x^14+x^10+x^8+x^7+x^4+x^3+1), one bit per enable.
module can_crc15
  import can_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [CRC_W-1:0]  crc
);

  logic [CRC_W-1:0] crc_q, crc_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0};
      if (din ^ crc_q[CRC_W-1]) crc_d = crc_d ^ CRC_POLY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= '0;
    else      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_rx.sv
// CAN receiver: bit timing, destuffing, base-frame decode, CRC check and ACK
// drive; presents each good frame with a one-cycle valid strobe.
module can_rx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int SAMPLE_PT    = 50
) (
  input logic      clk,
  input logic      rst,
  can_rx_if.master bus
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [PW-1:0] phase_q, phase_d;
  state_e        state_q, state_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          run_bit_q, run_bit_d;
  logic [2:0]    run_cnt_q, run_cnt_d;
  logic [10:0]   id_q, id_d;
  logic          rtr_q, rtr_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [63:0]   data_q, data_d;
  logic [14:0]   crc_rx_q, crc_rx_d;
  logic          ack_pend_q, ack_pend_d;
  logic          tx_q, tx_d;
  logic [10:0]   rx_id_q, rx_id_d;
  logic          rx_rtr_q, rx_rtr_d;
  logic [3:0]    rx_dlc_q, rx_dlc_d;
  logic [63:0]   rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  err_code_e     err_code_q, err_code_d;

  logic          fall_edge, wrap, sample, bit_in, destuff_zone, stuff_bit;
  logic          crc_clr, crc_en, err_hit, data_last;
  err_code_e     err_sel;
  logic [3:0]    dlc_next, nbytes;
  logic [6:0]    data_bits;
  logic [CRC_W-1:0] crc_val;

  can_crc15 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (bit_in),
    .crc (crc_val)
  );

  assign fall_edge    = rx_prev_q & ~rx_sync_q;
  assign wrap         = (phase_q == PW'(CLKS_PER_BIT - 1));
  assign sample       = (phase_q == PW'(SAMPLE_PT)) && (state_q != S_IDLE);
  assign bit_in       = rx_sync_q;
  assign destuff_zone = state_q inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
  assign stuff_bit    = destuff_zone && (run_cnt_q == 3'(STUFF_RUN));
  assign dlc_next     = {dlc_q[2:0], bit_in};
  // DLC values above 8 still carry eight data bytes.
  assign nbytes       = (dlc_q > 4'd8) ? 4'd8 : dlc_q;
  assign data_bits    = {nbytes, 3'b000};
  assign data_last    = ({1'b0, bit_cnt_q} == (data_bits - 7'd1));

  always_comb begin
    phase_d    = wrap ? '0 : phase_q + PW'(1);
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    run_bit_d  = run_bit_q;
    run_cnt_d  = run_cnt_q;
    id_d       = id_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    crc_rx_d   = crc_rx_q;
    ack_pend_d = ack_pend_q;
    tx_d       = tx_q;
    rx_id_d    = rx_id_q;
    rx_rtr_d   = rx_rtr_q;
    rx_dlc_d   = rx_dlc_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    err_code_d = err_code_q;
    crc_clr    = (state_q == S_IDLE);
    crc_en     = 1'b0;
    err_hit    = 1'b0;
    err_sel    = ERR_NONE;

    if (fall_edge) phase_d = '0;

    // The ACK request raised at the CRC delimiter becomes exactly one bit of dominant tx.
    if (wrap) begin
      tx_d       = ~ack_pend_q;
      ack_pend_d = 1'b0;
    end

    if (state_q == S_IDLE) begin
      run_bit_d = 1'b1;
      run_cnt_d = '0;
      bit_cnt_d = '0;
      if (fall_edge) begin
        state_d = S_SOF;
        data_d  = '0;
      end
    end else if (sample) begin
      if (stuff_bit) begin
        if (bit_in == run_bit_q) begin
          err_hit = 1'b1;
          err_sel = ERR_STUFF;
        end else begin
          run_bit_d = bit_in;
          run_cnt_d = 3'd1;
        end
      end else begin
        if (destuff_zone) begin
          if (bit_in == run_bit_q) begin
            run_cnt_d = run_cnt_q + 3'd1;
          end else begin
            run_bit_d = bit_in;
            run_cnt_d = 3'd1;
          end
        end
        bit_cnt_d = bit_cnt_q + 6'd1;
        case (state_q)
          S_SOF: begin
            crc_en = 1'b1;
            bit_cnt_d = '0;
            state_d = bit_in ? S_IDLE : S_ID;
          end
          S_ID: begin
            crc_en = 1'b1;
            id_d   = {id_q[9:0], bit_in};
            if (bit_cnt_q == 6'(ID_W - 1)) state_d = S_RTR;
          end
          S_RTR: begin
            crc_en  = 1'b1;
            rtr_d   = bit_in;
            state_d = S_IDE;
          end
          S_IDE: begin
            crc_en = 1'b1;
            if (bit_in) begin
              err_hit = 1'b1;
              err_sel = ERR_FORM;
            end else begin
              state_d = S_R0;
            end
          end
          S_R0: begin
            crc_en    = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_DLC;
          end
          S_DLC: begin
            crc_en = 1'b1;
            dlc_d  = dlc_next;
            if (bit_cnt_q == 6'(DLC_W - 1)) begin
              bit_cnt_d = '0;
              state_d   = (rtr_q || dlc_next == 4'd0) ? S_CRC : S_DATA;
            end
          end
          S_DATA: begin
            crc_en = 1'b1;
            // Bytes arrive MSB-first; byte k lands in data[8k+7:8k].
            data_d[{bit_cnt_q[5:3], ~bit_cnt_q[2:0]}] = bit_in;
            if (data_last) begin
              bit_cnt_d = '0;
              state_d   = S_CRC;
            end
          end
          S_CRC: begin
            crc_rx_d = {crc_rx_q[13:0], bit_in};
            if (bit_cnt_q == 6'(CRC_W - 1)) state_d = S_CRC_DEL;
          end
          S_CRC_DEL: begin
            if (crc_rx_q != crc_val) begin
              err_hit = 1'b1;
              err_sel = ERR_CRC;
            end else if (!bit_in) begin
              err_hit = 1'b1;
              err_sel = ERR_FORM;
            end else begin
              ack_pend_d = bus.ack_en;
              state_d    = S_ACK;
            end
          end
          S_ACK: state_d = S_ACK_DEL;
          S_ACK_DEL: begin
            bit_cnt_d = '0;
            if (!bit_in) begin
              err_hit = 1'b1;
              err_sel = ERR_FORM;
            end else begin
              state_d = S_EOF;
            end
          end
          S_EOF: begin
            if (!bit_in) begin
              err_hit = 1'b1;
              err_sel = ERR_FORM;
            end else if (bit_cnt_q == 6'(EOF_W - 1)) begin
              state_d    = S_IDLE;
              rx_valid_d = 1'b1;
              rx_id_d    = id_q;
              rx_rtr_d   = rtr_q;
              rx_dlc_d   = dlc_q;
              rx_data_d  = data_q;
              err_code_d = ERR_NONE;
            end
          end
          S_ERROR: begin
            if (!bit_in) bit_cnt_d = '0;
            else if (bit_cnt_q == 6'(ERR_RECESSIVE - 1)) state_d = S_IDLE;
          end
          default: ;
        endcase
      end

      if (err_hit) begin
        state_d    = S_ERROR;
        bit_cnt_d  = '0;
        rx_err_d   = 1'b1;
        err_code_d = err_sel;
        ack_pend_d = 1'b0;
        tx_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      phase_q    <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      run_bit_q  <= 1'b1;
      run_cnt_q  <= '0;
      id_q       <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      crc_rx_q   <= '0;
      ack_pend_q <= 1'b0;
      tx_q       <= 1'b1;
      rx_id_q    <= '0;
      rx_rtr_q   <= 1'b0;
      rx_dlc_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      rx_meta_q  <= bus.rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      phase_q    <= phase_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      run_bit_q  <= run_bit_d;
      run_cnt_q  <= run_cnt_d;
      id_q       <= id_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      crc_rx_q   <= crc_rx_d;
      ack_pend_q <= ack_pend_d;
      tx_q       <= tx_d;
      rx_id_q    <= rx_id_d;
      rx_rtr_q   <= rx_rtr_d;
      rx_dlc_q   <= rx_dlc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.rx_id    = rx_id_q;
  assign bus.rx_rtr   = rx_rtr_q;
  assign bus.rx_dlc   = rx_dlc_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;
  assign bus.err_code = err_code_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_can_rx.sv
// Directed bench for can_rx: table of whole frames plus hand-written
// sequences for stuff error, extended-frame rejection, SOF glitch and reset.
module tb_can_rx;

  localparam int CPB = 16;
  localparam int SP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  can_rx_if bus ();

  can_rx #(.CLKS_PER_BIT(CPB), .SAMPLE_PT(SP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int valid_seen  = 0;
  int err_seen    = 0;
  int tx_low_seen = 0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) valid_seen  = valid_seen + 1;
    if (bus.rx_err === 1'b1)   err_seen    = err_seen + 1;
    if (bus.tx === 1'b0)       tx_low_seen = tx_low_seen + 1;
  end

  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          flip;
    logic        crc_del;
    logic        ack_en;
    logic        exp_valid;
    logic [1:0]  exp_code;
    logic        exp_ack;
    logic [10:0] exp_id;
    logic        exp_rtr;
    logic [3:0]  exp_dlc;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  logic raw_q[$];
  logic frame_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    wait_clks(CPB);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame();
    foreach (frame_q[k]) drive_bit(frame_q[k]);
  endtask

  // Builds the on-wire bit sequence: raw fields, CRC-15 over SOF..data,
  // optional corruption of one raw bit after the CRC is computed, then
  // stuffing over SOF..CRC. trunc >= 0 stops after that many raw bits.
  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input int flip, input logic crc_del, input int trunc);
    logic [14:0] crc;
    logic        nxt;
    logic        last;
    int          run;
    int          nb;
    raw_q.delete();
    frame_q.delete();
    raw_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw_q.push_back(id[i]);
    raw_q.push_back(rtr);
    raw_q.push_back(ide);
    raw_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int b = 0; b < nb; b++)
      for (int i = 7; i >= 0; i--) raw_q.push_back(data[b*8 + i]);
    crc = '0;
    foreach (raw_q[k]) begin
      nxt = raw_q[k] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nxt) crc = crc ^ 15'h4599;
    end
    if (flip >= 0) raw_q[flip] = ~raw_q[flip];
    for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
    last = 1'b1;
    run  = 0;
    for (int k = 0; k < raw_q.size(); k++) begin
      if (k == trunc) return;
      if (run == 5) begin
        frame_q.push_back(~last);
        last = ~last;
        run  = 1;
      end
      frame_q.push_back(raw_q[k]);
      if (raw_q[k] == last) run = run + 1;
      else begin
        last = raw_q[k];
        run  = 1;
      end
    end
    frame_q.push_back(crc_del);
    frame_q.push_back(1'b1);
    frame_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) frame_q.push_back(1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tx"},       64'(bus.tx),       64'd1);
    check({tag, " rx_valid"}, 64'(bus.rx_valid), 64'd0);
    check({tag, " rx_err"},   64'(bus.rx_err),   64'd0);
    check({tag, " err_code"}, 64'(bus.err_code), 64'd0);
    check({tag, " busy"},     64'(bus.busy),     64'd0);
    check({tag, " rx_id"},    64'(bus.rx_id),    64'd0);
    check({tag, " rx_rtr"},   64'(bus.rx_rtr),   64'd0);
    check({tag, " rx_dlc"},   64'(bus.rx_dlc),   64'd0);
    check({tag, " rx_data"},  bus.rx_data,       64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, t0;

    vecs[0] = '{11'h123, 1'b0, 4'd2, 64'h000000000000CDAB, -1, 1'b1, 1'b1,
                1'b1, 2'd0, 1'b1, 11'h123, 1'b0, 4'd2, 64'h000000000000CDAB};
    vecs[1] = '{11'h000, 1'b0, 4'd8, 64'hFFFFFFFFFFFFFFFF, -1, 1'b1, 1'b1,
                1'b1, 2'd0, 1'b1, 11'h000, 1'b0, 4'd8, 64'hFFFFFFFFFFFFFFFF};
    vecs[2] = '{11'h123, 1'b0, 4'd2, 64'h000000000000CDAB, 22, 1'b1, 1'b1,
                1'b0, 2'd2, 1'b0, 11'h000, 1'b0, 4'd8, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{11'h555, 1'b0, 4'd1, 64'h000000000000005A, -1, 1'b1, 1'b0,
                1'b1, 2'd0, 1'b0, 11'h555, 1'b0, 4'd1, 64'h000000000000005A};
    vecs[4] = '{11'h0F0, 1'b0, 4'd0, 64'h0, -1, 1'b0, 1'b1,
                1'b0, 2'd3, 1'b0, 11'h555, 1'b0, 4'd1, 64'h000000000000005A};
    vecs[5] = '{11'h3A5, 1'b0, 4'd12, 64'h0123456789ABCDEF, -1, 1'b1, 1'b1,
                1'b1, 2'd0, 1'b1, 11'h3A5, 1'b0, 4'd12, 64'h0123456789ABCDEF};
    vecs[6] = '{11'h456, 1'b1, 4'd3, 64'hDEADBEEF, -1, 1'b1, 1'b1,
                1'b1, 2'd0, 1'b1, 11'h456, 1'b1, 4'd3, 64'h0};

    bus.rx     = 1'b1;
    bus.ack_en = 1'b1;
    rst        = 1'b0;
    wait_clks(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_clks(4);
    check("after reset busy", 64'(bus.busy), 64'd0);
    check("after reset tx",   64'(bus.tx),   64'd1);

    for (int i = 0; i < 7; i++) begin
      bus.ack_en = vecs[i].ack_en;
      v0 = valid_seen; e0 = err_seen; t0 = tx_low_seen;
      build_frame(vecs[i].id, vecs[i].rtr, 1'b0, vecs[i].dlc, vecs[i].data,
                  vecs[i].flip, vecs[i].crc_del, -1);
      send_frame();
      idle_bits(12);
      check($sformatf("row%0d valid_pulses", i), 64'(valid_seen - v0), 64'(vecs[i].exp_valid));
      check($sformatf("row%0d err_pulses", i),   64'(err_seen - e0),   64'(!vecs[i].exp_valid));
      check($sformatf("row%0d tx_low_clks", i),  64'(tx_low_seen - t0),
            vecs[i].exp_ack ? 64'(CPB) : 64'd0);
      check($sformatf("row%0d err_code", i), 64'(bus.err_code), 64'(vecs[i].exp_code));
      check($sformatf("row%0d rx_id", i),    64'(bus.rx_id),    64'(vecs[i].exp_id));
      check($sformatf("row%0d rx_rtr", i),   64'(bus.rx_rtr),   64'(vecs[i].exp_rtr));
      check($sformatf("row%0d rx_dlc", i),   64'(bus.rx_dlc),   64'(vecs[i].exp_dlc));
      check($sformatf("row%0d rx_data", i),  bus.rx_data,       vecs[i].exp_data);
      check($sformatf("row%0d busy", i),     64'(bus.busy),     64'd0);
    end
    bus.ack_en = 1'b1;

    // Six dominant bits inside the identifier.
    v0 = valid_seen; e0 = err_seen; t0 = tx_low_seen;
    frame_q.delete();
    frame_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame();
    idle_bits(12);
    check("stuff err_pulses", 64'(err_seen - e0),    64'd1);
    check("stuff err_code",   64'(bus.err_code),     64'd1);
    check("stuff valid",      64'(valid_seen - v0),  64'd0);
    check("stuff tx_low",     64'(tx_low_seen - t0), 64'd0);
    check("stuff busy",       64'(bus.busy),         64'd0);
    check("stuff rx_id held", 64'(bus.rx_id),        64'h456);
    v0 = valid_seen;
    build_frame(11'h321, 1'b0, 1'b0, 4'd1, 64'h77, -1, 1'b1, -1);
    send_frame();
    idle_bits(4);
    check("post-stuff valid",    64'(valid_seen - v0), 64'd1);
    check("post-stuff rx_id",    64'(bus.rx_id),       64'h321);
    check("post-stuff rx_data",  bus.rx_data,          64'h77);
    check("post-stuff err_code", 64'(bus.err_code),    64'd0);

    // Extended frame: form error at IDE, then 11 recessive samples to idle.
    e0 = err_seen; v0 = valid_seen;
    build_frame(11'h123, 1'b0, 1'b1, 4'd2, 64'h0, -1, 1'b1, 14);
    send_frame();
    idle_bits(10);
    check("ide err_pulses", 64'(err_seen - e0),   64'd1);
    check("ide err_code",   64'(bus.err_code),    64'd3);
    check("ide busy at 10", 64'(bus.busy),        64'd1);
    idle_bits(1);
    check("ide busy at 11", 64'(bus.busy),        64'd0);
    check("ide valid",      64'(valid_seen - v0), 64'd0);

    // Short dominant glitch: SOF samples recessive, no error.
    e0 = err_seen;
    bus.rx = 1'b0;
    wait_clks(5);
    check("glitch busy high", 64'(bus.busy), 64'd1);
    bus.rx = 1'b1;
    wait_clks(20);
    check("glitch busy low",   64'(bus.busy),      64'd0);
    check("glitch err_pulses", 64'(err_seen - e0), 64'd0);

    // Reset in the middle of the data field.
    build_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'hCDAB, -1, 1'b1, 25);
    send_frame();
    check("pre-rst busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    wait_clks(3);
    check_reset_outputs("in rst");
    rst    = 1'b1;
    bus.rx = 1'b1;
    idle_bits(3);
    check_reset_outputs("post rst");
    v0 = valid_seen; t0 = tx_low_seen;
    build_frame(11'h7FF, 1'b1, 1'b0, 4'd0, 64'h0, -1, 1'b1, -1);
    send_frame();
    idle_bits(4);
    check("rtr valid",   64'(valid_seen - v0),  64'd1);
    check("rtr tx_low",  64'(tx_low_seen - t0), 64'(CPB));
    check("rtr rx_id",   64'(bus.rx_id),        64'h7FF);
    check("rtr rx_rtr",  64'(bus.rx_rtr),       64'd1);
    check("rtr rx_dlc",  64'(bus.rx_dlc),       64'd0);
    check("rtr rx_data", bus.rx_data,           64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
